// File: rtl/otter_trap_pkg.sv
// Shared types and constants for the Otter trap sequencer.
// Holds the trap FSM state, CSR addresses and a PC alignment helper.
package otter_trap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAKE  = 2'd2
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;

  function automatic logic [31:0] align_pc(
    input logic [31:0] pc
  );
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_irq_sync.sv
// irq_in synchronizer chain with a rising-edge detector.
// Ports: clk, rst (sync, high), irq_in (async level), irq_edge (1-cycle).
module otter_irq_sync
  import otter_trap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic irq_edge
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_depth
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      lvl_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // edge is combinational off two flops, so pending
  // lands SYNC_STAGES+1 edges after irq_in rises
  assign irq_edge = sync_q[SYNC_STAGES-1] & ~lvl_q;

endmodule

// File: rtl/otter_trap_ctrl.sv
// Interrupt/trap sequencer: latches irq, drains the pipe, traps via mtvec.
// Ports: irq_in, CSR mie/mstatus/mtvec/mepc, commit info, pipe_empty;
//   out: stall_fetch, flush, redirect_valid/pc, int_taken, int_ret, next_pc.
module otter_trap_ctrl
  import otter_trap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_in,
  input  logic        mie,
  input  logic        mstatus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        commit_valid,
  input  logic [31:0] commit_next_pc,
  input  logic        mret_commit,
  input  logic        pipe_empty,
  output logic        stall_fetch,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        int_taken,
  output logic        int_ret,
  output logic [31:0] next_pc
);

  logic irq_edge;

  otter_irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .irq_edge(irq_edge)
  );

  trap_state_t state_q, state_d;
  logic        pending_q;
  logic [31:0] last_pc_q;
  logic [31:0] saved_pc_q;

  logic        irq_en;
  logic        mret_ev;
  logic [31:0] entry_pc;
  logic [31:0] drain_pc;

  logic        stall_d;
  logic        flush_d;
  logic        rdv_d;
  logic [31:0] rdpc_d;
  logic        taken_d;
  logic        ret_d;
  logic [31:0] npc_d;

  assign irq_en  = mie & mstatus;
  assign mret_ev = commit_valid & mret_commit;

  // PC to resume at if the drain starts now
  assign entry_pc = commit_valid ? commit_next_pc : last_pc_q;

  // an mret retiring mid-drain returns to mepc,
  // so the trap frame must record mepc instead
  assign drain_pc = !commit_valid ? saved_pc_q :
                    mret_commit   ? mepc       :
                                    commit_next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      stall_fetch    <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      int_taken      <= 1'b0;
      int_ret        <= 1'b0;
      next_pc        <= '0;
    end else begin
      state_q        <= state_d;
      stall_fetch    <= stall_d;
      flush          <= flush_d;
      redirect_valid <= rdv_d;
      redirect_pc    <= rdpc_d;
      int_taken      <= taken_d;
      int_ret        <= ret_d;
      next_pc        <= npc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mret_ev)
          state_d = IDLE;
        else if (pending_q && irq_en)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!irq_en)
          state_d = IDLE;
        else if (pipe_empty)
          state_d = TAKE;
      end
      TAKE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // computes the values the output flops take
  // at the edge that enters state_d
  always_comb begin
    stall_d = 1'b0;
    flush_d = 1'b0;
    rdv_d   = 1'b0;
    rdpc_d  = '0;
    taken_d = 1'b0;
    ret_d   = 1'b0;
    npc_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (mret_ev) begin
          ret_d   = 1'b1;
          flush_d = 1'b1;
          rdv_d   = 1'b1;
          rdpc_d  = align_pc(mepc);
        end else if (pending_q && irq_en) begin
          stall_d = 1'b1;
        end
      end
      DRAIN: begin
        if (irq_en) begin
          stall_d = 1'b1;
          if (pipe_empty) begin
            taken_d = 1'b1;
            npc_d   = drain_pc;
            flush_d = 1'b1;
            rdv_d   = 1'b1;
            rdpc_d  = align_pc(mtvec);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= 1'b0;
      last_pc_q  <= '0;
      saved_pc_q <= '0;
    end else begin
      // a fresh edge in the TAKE cycle outranks the clear
      if (irq_edge)
        pending_q <= 1'b1;
      else if (state_q == TAKE)
        pending_q <= 1'b0;
      if (commit_valid)
        last_pc_q <= commit_next_pc;
      if (state_q == IDLE)
        saved_pc_q <= entry_pc;
      else if (state_q == DRAIN)
        saved_pc_q <= drain_pc;
    end
  end

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Directed self-checking bench for otter_trap_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_otter_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_in;
  logic        mie;
  logic        mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        mret_commit;
  logic        pipe_empty;
  logic        stall_fetch;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_taken;
  logic        int_ret;
  logic [31:0] next_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  otter_trap_ctrl #(
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .mie           (mie),
    .mstatus       (mstatus),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .commit_valid  (commit_valid),
    .commit_next_pc(commit_next_pc),
    .mret_commit   (mret_commit),
    .pipe_empty    (pipe_empty),
    .stall_fetch   (stall_fetch),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .int_taken     (int_taken),
    .int_ret       (int_ret),
    .next_pc       (next_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".stall"}, {31'd0, stall_fetch}, 32'd0);
    chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
    chk({tag, ".rdv"},   {31'd0, redirect_valid}, 32'd0);
    chk({tag, ".rdpc"},  redirect_pc, 32'd0);
    chk({tag, ".taken"}, {31'd0, int_taken}, 32'd0);
    chk({tag, ".ret"},   {31'd0, int_ret}, 32'd0);
    chk({tag, ".npc"},   next_pc, 32'd0);
  endtask

  task automatic chk_take(input string tag,
                          input logic [31:0] npc,
                          input logic [31:0] vec);
    chk({tag, ".taken"}, {31'd0, int_taken}, 32'd1);
    chk({tag, ".ret"},   {31'd0, int_ret}, 32'd0);
    chk({tag, ".npc"},   next_pc, npc);
    chk({tag, ".rdpc"},  redirect_pc, vec);
    chk({tag, ".rdv"},   {31'd0, redirect_valid}, 32'd1);
    chk({tag, ".flush"}, {31'd0, flush}, 32'd1);
    chk({tag, ".stall"}, {31'd0, stall_fetch}, 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    irq_in         = 1'b0;
    mie            = 1'b1;
    mstatus        = 1'b1;
    mtvec          = 32'h100;
    mepc           = 32'h0;
    commit_valid   = 1'b0;
    commit_next_pc = 32'h0;
    mret_commit    = 1'b0;
    pipe_empty     = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;

    // basic trap: latency 3 to pending, then DRAIN
    irq_in = 1'b1;
    tick();
    tick();
    tick();
    chk("t1.sync_lat", {31'd0, stall_fetch}, 32'd0);
    tick();
    chk("t1.drain", {31'd0, stall_fetch}, 32'd1);
    commit_valid   = 1'b1;
    commit_next_pc = 32'h40;
    tick();
    chk("t1.drain2", {31'd0, stall_fetch}, 32'd1);
    chk("t1.notake", {31'd0, int_taken}, 32'd0);
    commit_next_pc = 32'h44;
    pipe_empty     = 1'b1;
    tick();
    chk_take("t1.take", 32'h44, 32'h100);
    commit_valid = 1'b0;
    tick();
    chk_quiet("t1.after");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1.cleared", {31'd0, stall_fetch}, 32'd0);
    end
    irq_in = 1'b0;
    tick();
    tick();
    tick();

    // masked request waits for mie
    mie            = 1'b0;
    pipe_empty     = 1'b0;
    commit_valid   = 1'b1;
    commit_next_pc = 32'h88;
    tick();
    commit_valid = 1'b0;
    irq_in = 1'b1;
    tick();
    tick();
    irq_in = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2.masked", {31'd0, stall_fetch}, 32'd0);
    end
    mie = 1'b1;
    tick();
    chk("t2.drain", {31'd0, stall_fetch}, 32'd1);
    pipe_empty = 1'b1;
    tick();
    chk_take("t2.take", 32'h88, 32'h100);
    tick();
    chk_quiet("t2.after");

    // mret in IDLE
    commit_valid   = 1'b1;
    mret_commit    = 1'b1;
    commit_next_pc = 32'h200;
    mepc           = 32'h44;
    tick();
    chk("t3.ret",   {31'd0, int_ret}, 32'd1);
    chk("t3.rdpc",  redirect_pc, 32'h44);
    chk("t3.rdv",   {31'd0, redirect_valid}, 32'd1);
    chk("t3.flush", {31'd0, flush}, 32'd1);
    chk("t3.taken", {31'd0, int_taken}, 32'd0);
    chk("t3.stall", {31'd0, stall_fetch}, 32'd0);
    commit_valid = 1'b0;
    mret_commit  = 1'b0;
    tick();
    chk_quiet("t3.after");

    // mstatus drop mid-drain, mret priority, mret in drain
    pipe_empty = 1'b0;
    irq_in     = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("t4.drain", {31'd0, stall_fetch}, 32'd1);
    mstatus = 1'b0;
    tick();
    chk("t4.drop",  {31'd0, stall_fetch}, 32'd0);
    chk("t4.taken", {31'd0, int_taken}, 32'd0);
    tick();
    tick();
    chk("t4.idle", {31'd0, stall_fetch}, 32'd0);
    mstatus        = 1'b1;
    commit_valid   = 1'b1;
    mret_commit    = 1'b1;
    commit_next_pc = 32'h304;
    mepc           = 32'h303;
    tick();
    chk("t4.prio.ret",   {31'd0, int_ret}, 32'd1);
    chk("t4.prio.stall", {31'd0, stall_fetch}, 32'd0);
    chk("t4.prio.rdpc",  redirect_pc, 32'h300);
    commit_valid = 1'b0;
    mret_commit  = 1'b0;
    tick();
    chk("t4.redrain", {31'd0, stall_fetch}, 32'd1);
    chk("t4.noret",   {31'd0, int_ret}, 32'd0);
    commit_valid   = 1'b1;
    mret_commit    = 1'b1;
    commit_next_pc = 32'h3C0;
    mepc           = 32'h3A0;
    pipe_empty     = 1'b1;
    tick();
    chk_take("t4.take", 32'h3A0, 32'h100);
    commit_valid = 1'b0;
    mret_commit  = 1'b0;
    tick();
    chk_quiet("t4.after");
    irq_in = 1'b0;
    tick();
    tick();
    tick();

    // second edge during TAKE keeps pending
    mtvec  = 32'h102;
    irq_in = 1'b1;
    tick();
    irq_in = 1'b0;
    tick();
    tick();
    irq_in = 1'b1;
    tick();
    chk("t5.drain", {31'd0, stall_fetch}, 32'd1);
    tick();
    chk_take("t5.take1", 32'h3C0, 32'h100);
    pipe_empty = 1'b0;
    tick();
    chk_quiet("t5.gap");
    tick();
    chk("t5.redrain", {31'd0, stall_fetch}, 32'd1);
    tick();
    chk("t5.hold",  {31'd0, stall_fetch}, 32'd1);
    chk("t5.wait",  {31'd0, int_taken}, 32'd0);
    commit_valid   = 1'b1;
    commit_next_pc = 32'h500;
    pipe_empty     = 1'b1;
    tick();
    chk_take("t5.take2", 32'h500, 32'h100);
    commit_valid = 1'b0;
    tick();
    chk_quiet("t5.after");
    irq_in = 1'b0;
    tick();
    tick();
    tick();

    // reset mid-drain drops the request
    pipe_empty = 1'b0;
    irq_in     = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("t6.drain", {31'd0, stall_fetch}, 32'd1);
    rst    = 1'b1;
    irq_in = 1'b0;
    tick();
    chk_quiet("t6.rst");
    rst        = 1'b0;
    pipe_empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6.notake", {31'd0, int_taken}, 32'd0);
      chk("t6.nostall", {31'd0, stall_fetch}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
